// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing constants for the VGA timing sequencer.
// Optional pixel divider is selected with the VGA_TIMING_PIXEL_DIV_EN macro (see top).
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_t;

  localparam int DEF_H_ACTIVE        = 640;
  localparam int DEF_H_FP            = 16;
  localparam int DEF_H_SYNC          = 96;
  localparam int DEF_H_BP            = 48;
  localparam int DEF_V_ACTIVE        = 480;
  localparam int DEF_V_FP            = 10;
  localparam int DEF_V_SYNC          = 2;
  localparam int DEF_V_BP            = 33;
  localparam int DEF_COUNTER_SIZE    = 11;
  localparam int DEF_SYNC_ACTIVE_LOW = 1;

  function automatic int calc_h_total(input int active, input int fp,
                                      input int sync_len, input int bp);
    return active + fp + sync_len + bp;
  endfunction

  function automatic int calc_v_total(input int active, input int fp,
                                      input int sync_len, input int bp);
    return active + fp + sync_len + bp;
  endfunction

  // Pin level for a sync output given whether it is logically asserted.
  function automatic logic sync_level(input logic asserted, input logic active_low);
    return asserted ^ active_low;
  endfunction

endpackage

// File: rtl/vga_timing_sequencer_if.sv
// Bundle of the sequencer's run control, timing outputs and debug phase state.
interface vga_timing_sequencer_if
  import vga_timing_pkg::*;
#(
  parameter int COUNTER_SIZE = DEF_COUNTER_SIZE
) ();

  // pixel_tick marks the cycle a new (pixel_x, pixel_y) first appears; there is no
  // back-pressure, so consumers must accept every tick while enable is high.
  logic                    enable;
  logic                    hsync;
  logic                    vsync;
  logic                    video_on;
  logic [COUNTER_SIZE-1:0] pixel_x;
  logic [COUNTER_SIZE-1:0] pixel_y;
  logic                    pixel_tick;
  logic                    line_start;
  logic                    frame_start;
  phase_t                  hphase;
  phase_t                  vphase;

  modport master (
    input  enable,
    output hsync, vsync, video_on, pixel_x, pixel_y,
    output pixel_tick, line_start, frame_start,
    output hphase, vphase
  );

  modport slave (
    output enable,
    input  hsync, vsync, video_on, pixel_x, pixel_y,
    input  pixel_tick, line_start, frame_start,
    input  hphase, vphase
  );

endinterface

// File: rtl/vga_axis_timer.sv
// One timing axis: a wrapping counter with its ACTIVE/FRONT/SYNC/BACK phase FSM.
// Reset parks the axis at the last count in BACK so the first advance wraps to 0.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int COUNTER_SIZE = DEF_COUNTER_SIZE
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    advance_i,
  input  logic [COUNTER_SIZE-1:0] active_i,
  input  logic [COUNTER_SIZE-1:0] fp_i,
  input  logic [COUNTER_SIZE-1:0] sync_i,
  input  logic [COUNTER_SIZE-1:0] bp_i,
  output logic [COUNTER_SIZE-1:0] count_o,
  output phase_t                  phase_o,
  output phase_t                  phase_next_o,
  output logic                    wrap_o
);

  localparam logic [COUNTER_SIZE-1:0] ONE = COUNTER_SIZE'(1);

  logic [COUNTER_SIZE-1:0] count_q, count_d;
  phase_t                  phase_q, phase_d;
  logic                    wrap;

  logic [COUNTER_SIZE-1:0] last_active;
  logic [COUNTER_SIZE-1:0] last_front;
  logic [COUNTER_SIZE-1:0] last_sync;
  logic [COUNTER_SIZE-1:0] last_count;

  // Each phase ends on the count just before the next boundary.
  assign last_active = active_i - ONE;
  assign last_front  = active_i + fp_i - ONE;
  assign last_sync   = active_i + fp_i + sync_i - ONE;
  assign last_count  = active_i + fp_i + sync_i + bp_i - ONE;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= last_count;
      phase_q <= BACK;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    wrap    = 1'b0;
    if (advance_i) begin
      if (count_q == last_count) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
      unique case (phase_q)
        ACTIVE:  if (count_q == last_active) phase_d = FRONT;
        FRONT:   if (count_q == last_front)  phase_d = SYNC;
        SYNC:    if (count_q == last_sync)   phase_d = BACK;
        BACK:    if (wrap)                   phase_d = ACTIVE;
        default: phase_d = BACK;
      endcase
    end
  end

  assign count_o      = count_q;
  assign phase_o      = phase_q;
  assign phase_next_o = phase_d;
  assign wrap_o       = wrap;

endmodule

// File: rtl/vga_timing_sequencer.sv
// Coordinated horizontal/vertical VGA timing with hold, restart and registered outputs.
// Define VGA_TIMING_PIXEL_DIV_EN to advance one pixel per two enabled clocks.
module vga_timing_sequencer
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter int COUNTER_SIZE    = DEF_COUNTER_SIZE,
  parameter int SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
  input  logic                   control_clock,
  input  logic                   reset,
  vga_timing_sequencer_if.master bus
);

  localparam int H_TOTAL = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [COUNTER_SIZE-1:0] H_ACT_C  = COUNTER_SIZE'(H_ACTIVE);
  localparam logic [COUNTER_SIZE-1:0] H_FP_C   = COUNTER_SIZE'(H_FP);
  localparam logic [COUNTER_SIZE-1:0] H_SYNC_C = COUNTER_SIZE'(H_SYNC);
  localparam logic [COUNTER_SIZE-1:0] H_BP_C   = COUNTER_SIZE'(H_BP);
  localparam logic [COUNTER_SIZE-1:0] V_ACT_C  = COUNTER_SIZE'(V_ACTIVE);
  localparam logic [COUNTER_SIZE-1:0] V_FP_C   = COUNTER_SIZE'(V_FP);
  localparam logic [COUNTER_SIZE-1:0] V_SYNC_C = COUNTER_SIZE'(V_SYNC);
  localparam logic [COUNTER_SIZE-1:0] V_BP_C   = COUNTER_SIZE'(V_BP);

  localparam logic SYNC_AL   = (SYNC_ACTIVE_LOW != 0);
  localparam logic SYNC_IDLE = SYNC_AL;

  logic                    advance;
  logic                    h_wrap, v_wrap;
  logic                    v_advance;
  logic [COUNTER_SIZE-1:0] h_count, v_count;
  phase_t                  hphase, hphase_next;
  phase_t                  vphase, vphase_next;

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic video_on_q, video_on_d;
  logic pixel_tick_q, line_start_q, frame_start_q;

`ifdef VGA_TIMING_PIXEL_DIV_EN
  // Divide bit only moves on enabled cycles, so a pause never slips a half pixel.
  logic div_q;

  always_ff @(posedge control_clock) begin
    if (reset) begin
      div_q <= 1'b0;
    end else if (bus.enable) begin
      div_q <= ~div_q;
    end
  end

  assign advance = bus.enable & div_q;
`else
  assign advance = bus.enable;
`endif

  vga_axis_timer #(.COUNTER_SIZE(COUNTER_SIZE)) u_h_axis (
    .clk_i        (control_clock),
    .rst_i        (reset),
    .advance_i    (advance),
    .active_i     (H_ACT_C),
    .fp_i         (H_FP_C),
    .sync_i       (H_SYNC_C),
    .bp_i         (H_BP_C),
    .count_o      (h_count),
    .phase_o      (hphase),
    .phase_next_o (hphase_next),
    .wrap_o       (h_wrap)
  );

  assign v_advance = h_wrap & advance;

  vga_axis_timer #(.COUNTER_SIZE(COUNTER_SIZE)) u_v_axis (
    .clk_i        (control_clock),
    .rst_i        (reset),
    .advance_i    (v_advance),
    .active_i     (V_ACT_C),
    .fp_i         (V_FP_C),
    .sync_i       (V_SYNC_C),
    .bp_i         (V_BP_C),
    .count_o      (v_count),
    .phase_o      (vphase),
    .phase_next_o (vphase_next),
    .wrap_o       (v_wrap)
  );

  // Decoded from next-state phases so these registers line up with the counters.
  always_comb begin
    hsync_d    = sync_level(hphase_next == SYNC, SYNC_AL);
    vsync_d    = sync_level(vphase_next == SYNC, SYNC_AL);
    video_on_d = (hphase_next == ACTIVE) && (vphase_next == ACTIVE);
  end

  always_ff @(posedge control_clock) begin
    if (reset) begin
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      video_on_q    <= 1'b0;
      pixel_tick_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_tick_q  <= advance;
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap & v_wrap;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.video_on    = video_on_q;
  assign bus.pixel_x     = h_count;
  assign bus.pixel_y     = v_count;
  assign bus.pixel_tick  = pixel_tick_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.hphase      = hphase;
  assign bus.vphase      = vphase;

endmodule

// File: doc/vga_timing_sequencer.md
# vga_timing_sequencer

Top-level timing sequencer for the VGA controller. It owns the horizontal and vertical pixel counters and sequences each axis through its active, front porch, sync and back porch phases. It produces registered hsync, vsync, video_on and pixel coordinates, plus line and frame strobes for the pixel-fetch logic. It replaces free-running per-axis sync generators with a single coordinated sequencer that can be held, restarted and clock-divided.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines
- COUNTER_SIZE, 11, width of each axis counter; must hold H_TOTAL-1 and V_TOTAL-1
- SYNC_ACTIVE_LOW, 1, 1 means the sync outputs are low while asserted

Ports:
- control_clock  in  1  single clock
- reset  in  1  synchronous, active-high
- enable  in  1  run; when low, all state holds
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- video_on  out  1  high when both axes are in ACTIVE
- pixel_x  out  COUNTER_SIZE  raw horizontal count h
- pixel_y  out  COUNTER_SIZE  raw vertical count v
- pixel_tick  out  1  one-cycle strobe; the counters advance on this cycle
- line_start  out  1  one-cycle strobe when h becomes 0
- frame_start  out  1  one-cycle strobe when (h,v) becomes (0,0)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Each axis runs a 4-state phase machine in the order ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Horizontal phase boundaries fall at h = H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, and wrap at H_TOTAL-1 -> 0.
  - Vertical boundaries are the same with V_* parameters.
- h advances on every pixel_tick.
- v advances only on a pixel_tick where h wraps. It wraps V_TOTAL-1 -> 0.
- hsync is asserted iff the horizontal phase is SYNC; vsync is asserted iff the vertical phase is SYNC.
- video_on = (hphase == ACTIVE) and (vphase == ACTIVE).
- Reset loads h = H_TOTAL-1, v = V_TOTAL-1 and both phases = BACK. The first pixel_tick after reset therefore wraps to (0,0) and fires both line_start and frame_start.
- enable low: counters, phases, sync outputs and video_on hold. pixel_tick, line_start and frame_start are 0.
- Reset has priority over enable and over a tick in the same cycle.

## Timing
- All outputs are registered and update on the same edge as the counters, so they always describe the current (h,v) with no skew between outputs.
- Reset values, held while reset is high:
  - hsync and vsync at their deasserted level
  - video_on 0
  - pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1
  - pixel_tick, line_start, frame_start all 0
- Strobe alignment:
  - line_start is high in the cycle in which pixel_x first reads 0.
  - frame_start is high in the cycle in which (pixel_x, pixel_y) first reads (0,0).
  - pixel_tick is high in the cycle the new count first appears.
- Latency from enable rising to the first advance: 1 cycle without the divider, 2 cycles with it.
- Reset mid-frame takes effect on the next edge. No partial line is emitted after reset releases.

## Configuration
- VGA_TIMING_PIXEL_DIV_EN defined: an internal divide bit resets to 0 and toggles on every enabled cycle. Counters advance only on enabled cycles where this bit was 1, i.e. one pixel per 2 enabled clocks (50 MHz in, 25 MHz pixel rate). The divide bit holds while enable is low.
- Not defined: counters advance on every enabled cycle (control_clock is the pixel clock).

## Structure
- Package vga_timing_pkg holds:
  - the phase enum {ACTIVE, FRONT, SYNC, BACK}
  - default 640x480@60 constants
  - H_TOTAL/V_TOTAL computation functions
- Sub-module vga_axis_timer holds one counter plus its phase FSM, with inputs advance/active/fp/sync/bp and outputs count/phase/wrap. It is instantiated twice; the vertical instance's advance is the horizontal instance's wrap ANDed with advance.

## Test plan
- Reset, then enable=1 (no divider) -> the first edge gives pixel_x=0, pixel_y=0, video_on=1, line_start=1, frame_start=1.
- Run one line -> hsync is low exactly while pixel_x is 656..751. video_on falls at pixel_x=640. Wrap 799->0 sets line_start and increments pixel_y.
- Run a full frame -> vsync is low for pixel_y 490..491. frame_start occurs once per 420000 ticks, at (0,0).
- enable=0 for 37 cycles mid-line -> all outputs frozen and strobes 0. Resuming continues from the held count with no skipped pixel.
- Assert reset at (300,200) during a tick -> the next cycle reads (799,524) with sync deasserted. After release, the first tick fires frame_start.
- With VGA_TIMING_PIXEL_DIV_EN defined -> pixel_tick every 2nd enabled cycle, 1600 clocks per line, hsync low for 192 clocks.
